// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants and instruction-fetch state encoding.
// Pure declarations; no logic and no latency.
// Not applicable (package only, no handshakes).
package riscv_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP,
    S_FAULT
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Sequential instruction fetch: owns the PC, one outstanding imem request, redirect squash.
// Latency: request accepted -> response -> if_valid the following cycle (>= 3 cycles/instr).
// Backpressure: if_ready low holds the instruction in place; imem_req_ready low holds the request.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirect traps into S_FAULT with fetch_fault.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [6:0]      if_opcode,
  output logic [PC_W-1:0] if_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  output logic            fetch_fault
);

  fetch_state_t    state;
  fetch_state_t    after_drain;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic [PC_W-1:0] if_pc_q;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] redir_pc;
  logic            accept;
  logic            outstanding;

  assign accept = (state == S_REQ) && imem_req_ready;

  // True when, after this edge, memory still owes us a response that must be thrown away.
  // A response landing in S_DROP on the redirect cycle itself completes the drain.
  assign outstanding = accept
                     || ((state == S_WAIT || state == S_DROP) && !imem_rsp_valid);

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q;
  logic redir_misaligned;

  assign redir_pc         = redirect_target;
  assign redir_misaligned = |redirect_target[1:0];
  assign after_drain      = fault_q ? S_FAULT : S_REQ;
  assign fetch_fault      = fault_q;
`else
  // Low two bits are forced to zero so the PC always stays word aligned.
  assign redir_pc    = redirect_target & ~PC_W'(3);
  assign after_drain = S_REQ;
  assign fetch_fault = 1'b0;
`endif

  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;
  assign if_valid       = (state == S_HOLD);
  assign if_instr       = (state == S_HOLD) ? instr_q : NOP_INSTR;
  assign if_opcode      = if_instr[6:0];
  assign if_pc          = if_pc_q;

  // Fetch FSM and PC: redirect wins over every other event on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      req_pc  <= '0;
      if_pc_q <= '0;
      instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q <= 1'b0;
`endif
    end else if (redirect_valid && state != S_FAULT) begin
      pc <= redir_pc;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redir_misaligned) fault_q <= 1'b1;
      if (outstanding)                      state <= S_DROP;
      else if (redir_misaligned || fault_q) state <= S_FAULT;
      else                                  state <= S_REQ;
`else
      state <= outstanding ? S_DROP : S_REQ;
`endif
    end else begin
      case (state)
        S_REQ: begin
          if (accept) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            instr_q <= imem_rsp_data;
            if_pc_q <= req_pc;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            pc    <= pc + PC_W'(4);
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state <= after_drain;
        end
`ifdef FETCH_MISALIGN_CHK_EN
        S_FAULT: state <= S_FAULT;
`endif
        default: state <= S_REQ;
      endcase
    end
  end

  // Memory may only answer while a request is owed; anything else is a protocol error.
  assert property (@(posedge clk) disable iff (!rst_n)
                   imem_rsp_valid |-> (state != S_REQ && state != S_HOLD));

endmodule
